// File: rtl/seq_detector_param.sv
// Serial pattern detector: matches the last LEN qualified samples of x against PATTERN.
// Optional saturating match counter enabled by defining SEQ_DETECTOR_MATCH_COUNT_EN.
module seq_detector_param #(
  parameter int          LEN     = 4,
  parameter logic [15:0] PATTERN = 16'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       x,
  output logic                       y,
  output logic [$clog2(LEN+1)-1:0]   fill
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]           match_cnt
`endif
);

  localparam int             FW       = $clog2(LEN + 1);
  localparam logic [LEN-1:0] PAT      = PATTERN[LEN-1:0];
  localparam logic [FW-1:0]  FILL_MAX = FW'(LEN);

  logic [LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           y_q, y_d;
  logic [LEN-1:0] hist_shift;
  logic [FW-1:0]  fill_inc;
  logic           match;

`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    y_d        = 1'b0;
    hist_shift = {hist_q[LEN-2:0], x};
    fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    match      = 1'b0;
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
    cnt_d      = cnt_q;
`endif
    if (en) begin
      // fill gating keeps an all-zero PATTERN from matching the reset history
      match  = (fill_inc == FILL_MAX) && (hist_shift == PAT);
      hist_d = hist_shift;
      fill_d = (match && !OVERLAP) ? '0 : fill_inc;
      y_d    = match;
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
      if (match && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
      cnt_q  <= '0;
`endif
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign y    = y_q;
  assign fill = fill_q;
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
  assign match_cnt = cnt_q;
`endif

endmodule
